// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N_IN:1 word multiplexer with a registered, skid-buffered output stage.
// Latency: 1 cycle from an accepted input beat to out_valid/out_data; 1 beat/cycle sustained.
// Backpressure: out_ready low holds the output word; one extra beat parks in a skid register,
//   then in_ready (registered, never combinational from out_ready) drops until the skid drains.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous, active-high; clears held beats, out_data=0, sel_err=0, in_ready=1
//   in_data    - N_IN packed words, input k at [k*WIDTH +: WIDTH]
//   sel        - index of the word to capture, sampled with in_valid
//   in_valid   - in_data/sel valid this cycle
//   in_ready   - block accepts a beat this cycle (equals NOT skid_valid, registered)
//   out_data   - selected word
//   out_valid  - out_data is valid
//   out_ready  - consumer takes out_data this cycle
//   sel_err    - sticky out-of-range-select flag
//
// Optional feature macro: MUX_SEL_CHECK_EN
//   defined   : a beat with sel >= N_IN captures 0 and sets sel_err until reset
//   undefined : sel_err is tied to 0 and an out-of-range sel selects input 0

module mux_nx1_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  // Occupancy of the two-entry output stage.
  //   ST_EMPTY : nothing held
  //   ST_ONE   : output register holds a beat
  //   ST_FULL  : output register and skid register both hold beats
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] sel_word;

`ifdef MUX_SEL_CHECK_EN
  logic             sel_oob;
  logic             sel_err_q, sel_err_d;
`endif

  // ------------------------------------------------------------------
  // Handshakes. in_ready_q is low only in ST_FULL, so no beat can be
  // accepted while the skid register is occupied.
  // ------------------------------------------------------------------
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign consume   = out_valid && out_ready;

  // ------------------------------------------------------------------
  // Word select. The default covers any sel value that matches no input;
  // in the checked build that case is forced to zero and flagged.
  // ------------------------------------------------------------------
  always_comb begin
    sel_word = in_data[WIDTH-1:0];
`ifdef MUX_SEL_CHECK_EN
    sel_oob  = 1'b1;
`endif
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
`ifdef MUX_SEL_CHECK_EN
        sel_oob  = 1'b0;
`endif
      end
    end
`ifdef MUX_SEL_CHECK_EN
    if (sel_oob) begin
      sel_word = '0;
    end
`endif
  end

  // ------------------------------------------------------------------
  // Next-state and datapath steering.
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_ONE;
          out_data_d = sel_word;
        end
      end

      ST_ONE: begin
        if (accept && consume) begin
          // Old word leaves, new word replaces it in place.
          out_data_d = sel_word;
        end else if (accept) begin
          // Output is stalled: park the new word behind it.
          state_d     = ST_FULL;
          skid_data_d = sel_word;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // in_ready_q is low here, so only a consume can move the state.
        if (consume) begin
          state_d    = ST_ONE;
          out_data_d = skid_data_q;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Registered ready: reflects whether the skid will be free next cycle.
    in_ready_d = (state_d != ST_FULL);
  end

`ifdef MUX_SEL_CHECK_EN
  always_comb begin
    sel_err_d = sel_err_q | (accept & sel_oob);
  end
`endif

  // ------------------------------------------------------------------
  // State registers.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
`ifdef MUX_SEL_CHECK_EN
      sel_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
`ifdef MUX_SEL_CHECK_EN
      sel_err_q   <= sel_err_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = out_data_q;

`ifdef MUX_SEL_CHECK_EN
  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
module tb_mux_nx1_pipe;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic mon_en;

  // Main instance: WIDTH=32, N_IN=4
  logic [127:0] m_in_data;
  logic [1:0]   m_sel;
  logic         m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_sel_err;
  logic [31:0]  m_out_data;
  logic [31:0]  m_words [4];
  logic [31:0]  mq [$];
  logic [31:0]  m_exp;

  // Select-range instance: WIDTH=32, N_IN=3
  logic [95:0]  t_in_data;
  logic [1:0]   t_sel;
  logic         t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_sel_err;
  logic [31:0]  t_out_data;

  // Random instance: WIDTH=8, N_IN=5
  logic [39:0]  r_in_data;
  logic [2:0]   r_sel;
  logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_sel_err;
  logic [7:0]   r_out_data;
  logic [7:0]   rq [$];
  logic [7:0]   r_exp;
  int           r_accepts;
  int           r_consumes;

  mux_nx1_pipe #(.WIDTH(32), .N_IN(4)) u_dut (
    .clk(clk), .reset(reset), .in_data(m_in_data), .sel(m_sel),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .out_data(m_out_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .sel_err(m_sel_err)
  );

  mux_nx1_pipe #(.WIDTH(32), .N_IN(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(t_in_data), .sel(t_sel),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .out_data(t_out_data),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .sel_err(t_sel_err)
  );

  mux_nx1_pipe #(.WIDTH(8), .N_IN(5)) u_dut5 (
    .clk(clk), .reset(reset), .in_data(r_in_data), .sel(r_sel),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .out_data(r_out_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .sel_err(r_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the 8-bit, 5-input instance.
  function automatic logic [7:0] model5(input logic [39:0] d, input logic [2:0] s);
    if (int'(s) >= 5) begin
`ifdef MUX_SEL_CHECK_EN
      return 8'h00;
`else
      return d[7:0];
`endif
    end
    return d[int'(s)*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the main instance: consumes are compared before the
  // beat being accepted at the same edge is queued.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
    end else if (mon_en) begin
      if (m_out_valid && m_out_ready) begin
        total++;
        if (mq.size() == 0) begin
          bad++;
          $display("FAIL main_sb_extra: got beat %h with nothing expected", m_out_data);
        end else begin
          m_exp = mq.pop_front();
          if (m_out_data !== m_exp) begin
            bad++;
            $display("FAIL main_sb_order: got %h want %h", m_out_data, m_exp);
          end
        end
      end
      if (m_in_valid && m_in_ready) mq.push_back(m_in_data[int'(m_sel)*32 +: 32]);
    end
  end

  // Scoreboard for the random instance; queue depth doubles as an
  // occupancy model, so ready/valid are checked against it every cycle.
  always @(negedge clk) begin
    if (reset) begin
      rq.delete();
    end else if (mon_en) begin
      total++;
      if (r_in_ready !== (rq.size() < 2)) begin
        bad++;
        $display("FAIL rnd_in_ready: got %b want %b", r_in_ready, (rq.size() < 2));
      end
      total++;
      if (r_out_valid !== (rq.size() > 0)) begin
        bad++;
        $display("FAIL rnd_out_valid: got %b want %b", r_out_valid, (rq.size() > 0));
      end
      if (r_out_valid && r_out_ready) begin
        r_consumes++;
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL rnd_sb_extra: got beat %h with nothing expected", r_out_data);
        end else begin
          r_exp = rq.pop_front();
          if (r_out_data !== r_exp) begin
            bad++;
            $display("FAIL rnd_sb_data: got %h want %h", r_out_data, r_exp);
          end
        end
      end
      if (r_in_valid && r_in_ready) begin
        r_accepts++;
        rq.push_back(model5(r_in_data, r_sel));
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    m_in_valid = 1'b1;
    m_sel = 2'd2;
    m_out_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (m_out_valid !== 1'b0) begin
        bad++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid);
      end
      total++;
      if (m_in_ready !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
      end
    end
    total++;
    if (m_out_data !== 32'h0) begin
      bad++; $display("FAIL reset_out_data: got %h want 0", m_out_data);
    end
    total++;
    if (m_sel_err !== 1'b0 || t_sel_err !== 1'b0) begin
      bad++; $display("FAIL reset_sel_err: got %b/%b want 0/0", m_sel_err, t_sel_err);
    end
    reset = 1'b0;
    m_in_valid = 1'b0;
    tick();
    total++;
    if (m_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_accept: got out_valid %b want 0", m_out_valid);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    m_out_ready = 1'b1;
    m_in_valid = 1'b1;
    m_sel = 2'd2;
    tick();
    m_in_valid = 1'b0;
    total++;
    if (m_out_valid !== 1'b1 || m_out_data !== 32'hC2) begin
      bad++; $display("FAIL basic_sel2: got v=%b d=%h want v=1 d=000000c2", m_out_valid, m_out_data);
    end
    total++;
    if (m_in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_in_ready: got %b want 1", m_in_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_in_valid = 1'b1;
      m_sel = 2'(i);
      tick();
      total++;
      if (m_out_valid !== 1'b1 || m_out_data !== m_words[i]) begin
        bad++; $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%h", i, m_out_valid, m_out_data, m_words[i]);
      end
    end
    m_in_valid = 1'b0;
    tick();
    total++;
    if (m_out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_end: got out_valid %b want 0", m_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    m_out_ready = 1'b0;
    m_in_valid = 1'b1;
    m_sel = 2'd1;
    tick();
    total++;
    if (m_out_data !== m_words[1] || m_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_first: got d=%h rdy=%b want d=%h rdy=1", m_out_data, m_in_ready, m_words[1]);
    end
    m_sel = 2'd2;
    tick();
    total++;
    if (m_in_ready !== 1'b0 || m_out_data !== m_words[1]) begin
      bad++; $display("FAIL bp_full: got rdy=%b d=%h want rdy=0 d=%h", m_in_ready, m_out_data, m_words[1]);
    end
    m_sel = 2'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (m_in_ready !== 1'b0 || m_out_data !== m_words[1] || m_out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_stall_%0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", i, m_in_ready, m_out_valid, m_out_data, m_words[1]);
      end
    end
    m_out_ready = 1'b1;
    tick();
    total++;
    if (m_out_data !== m_words[2] || m_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_drain_skid: got d=%h rdy=%b want d=%h rdy=1", m_out_data, m_in_ready, m_words[2]);
    end
    tick();
    m_in_valid = 1'b0;
    total++;
    if (m_out_data !== m_words[3] || m_out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_third: got v=%b d=%h want v=1 d=%h", m_out_valid, m_out_data, m_words[3]);
    end
    tick();
    total++;
    if (m_out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty: got out_valid %b want 0", m_out_valid);
    end
  endtask

  task automatic test_reset_full();
    m_out_ready = 1'b0;
    m_in_valid = 1'b1;
    m_sel = 2'd0;
    tick();
    m_sel = 2'd1;
    tick();
    m_in_valid = 1'b0;
    total++;
    if (m_in_ready !== 1'b0) begin
      bad++; $display("FAIL rstfull_setup: got in_ready %b want 0", m_in_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_out_data !== 32'h0) begin
      bad++; $display("FAIL rstfull_clear: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", m_out_valid, m_in_ready, m_out_data);
    end
    m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (m_out_valid !== 1'b0) begin
        bad++; $display("FAIL rstfull_stale_%0d: got out_valid %b d=%h want 0", i, m_out_valid, m_out_data);
      end
    end
  endtask

  task automatic test_sel_range();
    logic [31:0] exp_d;
    logic        exp_err;
`ifdef MUX_SEL_CHECK_EN
    exp_d = 32'h0;
    exp_err = 1'b1;
`else
    exp_d = 32'h3333_0000;
    exp_err = 1'b0;
`endif
    t_out_ready = 1'b1;
    t_in_valid = 1'b1;
    t_sel = 2'd3;
    tick();
    total++;
    if (t_out_valid !== 1'b1 || t_out_data !== exp_d) begin
      bad++; $display("FAIL sel_oob_data: got v=%b d=%h want v=1 d=%h", t_out_valid, t_out_data, exp_d);
    end
    total++;
    if (t_sel_err !== exp_err) begin
      bad++; $display("FAIL sel_oob_err: got %b want %b", t_sel_err, exp_err);
    end
    t_sel = 2'd1;
    tick();
    t_in_valid = 1'b0;
    total++;
    if (t_out_data !== 32'h3333_0001 || t_sel_err !== exp_err) begin
      bad++; $display("FAIL sel_legal_after: got d=%h err=%b want d=33330001 err=%b", t_out_data, t_sel_err, exp_err);
    end
    repeat (2) tick();
    total++;
    if (t_sel_err !== exp_err) begin
      bad++; $display("FAIL sel_err_sticky: got %b want %b", t_sel_err, exp_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (t_sel_err !== 1'b0) begin
      bad++; $display("FAIL sel_err_reset: got %b want 0", t_sel_err);
    end
  endtask

  task automatic test_random();
    logic [63:0] rv;
    r_accepts = 0;
    r_consumes = 0;
    for (int i = 0; i < 10000; i++) begin
      rv = {$urandom(), $urandom()};
      r_in_data = rv[39:0];
      r_sel = 3'($urandom_range(0, 7));
      r_in_valid = ($urandom_range(0, 2) != 0);
      r_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    r_in_valid = 1'b0;
    r_out_ready = 1'b1;
    for (int i = 0; i < 10 && rq.size() != 0; i++) tick();
    tick();
    total++;
    if (rq.size() != 0 || r_out_valid !== 1'b0) begin
      bad++; $display("FAIL rnd_drain: got %0d pending v=%b want 0 pending v=0", rq.size(), r_out_valid);
    end
    total++;
    if (r_accepts != r_consumes || r_accepts == 0) begin
      bad++; $display("FAIL rnd_count: got accepts=%0d consumes=%0d want equal and nonzero", r_accepts, r_consumes);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    m_words[0] = 32'hA0;
    m_words[1] = 32'hB1;
    m_words[2] = 32'hC2;
    m_words[3] = 32'hD3;
    m_in_data = {m_words[3], m_words[2], m_words[1], m_words[0]};
    m_sel = 2'd0;
    m_in_valid = 1'b0;
    m_out_ready = 1'b0;
    t_in_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    t_sel = 2'd0;
    t_in_valid = 1'b0;
    t_out_ready = 1'b1;
    r_in_data = '0;
    r_sel = 3'd0;
    r_in_valid = 1'b0;
    r_out_ready = 1'b1;

    test_reset();
    test_basic();
    test_stream();
    test_back_to_back();
    test_reset_full();
    test_sel_range();
    test_random();

    total++;
    if (mq.size() != 0) begin
      bad++; $display("FAIL main_sb_leftover: got %0d pending want 0", mq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
